// File: rtl/cnn_pkg.sv
// Shared types and size helpers for the cnn input-side blocks.
package cnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int PIX_W_DEF = 8;

    // clog2 that never returns 0, so single-entry sizes still get a 1-bit counter
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int ADDR_W_DEF = clog2_min1(IMG_W_DEF * IMG_H_DEF);
    localparam int ROW_W_DEF  = clog2_min1(IMG_H_DEF);

endpackage

// File: rtl/img_buf_ram.sv
// Simple dual-port image buffer: one write port, one registered read port (BRAM style).
module img_buf_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 784,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/img_row_streamer.sv
// Buffers one raster image, then streams it row by row: PREFILL_ROWS back to back,
// every later row gated by a consumer interrupt edge.
module img_row_streamer
    import cnn_pkg::*;
#(
    parameter int IMG_W        = IMG_W_DEF,
    parameter int IMG_H        = IMG_H_DEF,
    parameter int PIX_W        = PIX_W_DEF,
    parameter int CH           = 1,
    parameter int PREFILL_ROWS = 4,
    localparam int DW     = PIX_W * CH,
    localparam int NPIX   = IMG_W * IMG_H,
    localparam int ADDR_W = clog2_min1(NPIX),
    localparam int ROW_W  = clog2_min1(IMG_H)
) (
    input  logic             axi_clk,
    input  logic             axi_rst_n,
    input  logic             i_wr_valid,
    input  logic [DW-1:0]    i_wr_data,
    output logic             o_wr_ready,
    output logic             o_load_done,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic             i_flip,
    input  logic             i_intr,
    output logic             o_data_valid,
    output logic [DW-1:0]    o_data,
    output logic [ROW_W-1:0] o_row_idx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int COL_W = clog2_min1(IMG_W);
    localparam int PND_W = clog2_min1(IMG_H + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W:0]    PREFILL   = (ROW_W + 1)'(PREFILL_ROWS);
    localparam logic [PND_W-1:0]  PND_MAX   = PND_W'(IMG_H);

    state_t            state, state_n;
    logic [ADDR_W-1:0] wptr, rd_addr;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row, src_row, row_q1;
    logic [PND_W-1:0]  pending;
    logic [2:1]        vld_pipe;
    logic [DW-1:0]     ram_q;
    logic              armed, flip_q, intr_q;
    logic              ctl_ok, wr_acc, clr_go, start_go, issue, consume, intr_edge;

    // Control (load/clear/start) only once the tail of a previous stream has drained
    assign ctl_ok    = (state == S_IDLE) || (state == S_DONE && vld_pipe == 2'b00);
    assign o_wr_ready = armed && !o_load_done && ctl_ok;
    assign wr_acc    = i_wr_valid && o_wr_ready;
    assign clr_go    = ctl_ok && i_clear;
    assign intr_edge = i_intr && !intr_q;
    assign src_row   = flip_q ? (LAST_ROW - row) : row;
    assign rd_addr   = ADDR_W'(src_row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    assign o_data_valid = vld_pipe[2];

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) state <= S_IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        issue    = 1'b0;
        consume  = 1'b0;
        start_go = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (clr_go) begin
                    state_n = S_IDLE;
                end else if (ctl_ok && i_start && o_load_done) begin
                    start_go = 1'b1;
                    state_n  = S_ROW;
                end
            end
            S_ROW: begin
                issue = 1'b1;
                if (col == LAST_COL) state_n = (row == LAST_ROW) ? S_DONE : S_GAP;
            end
            S_GAP, S_WAIT: begin
                // row already points at the next row here
                if (state == S_GAP && {1'b0, row} < PREFILL) begin
                    state_n = S_ROW;
                end else if (pending != '0 || intr_edge) begin
                    consume = 1'b1;
                    state_n = S_ROW;
                end else begin
                    state_n = S_WAIT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            armed       <= 1'b0;
            wptr        <= '0;
            o_load_done <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            armed  <= 1'b1;
            intr_q <= i_intr;
            if (clr_go) begin
                wptr        <= '0;
                o_load_done <= 1'b0;
            end else if (wr_acc) begin
                o_load_done <= (wptr == LAST_ADDR);
                wptr        <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            flip_q  <= 1'b0;
            row     <= '0;
            col     <= '0;
            pending <= '0;
        end else begin
            if (start_go) begin
                flip_q <= i_flip;
                row    <= '0;
                col    <= '0;
            end else if (issue) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    if (row != LAST_ROW) row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (start_go) begin
                pending <= '0;
            end else if (state != S_IDLE && state != S_DONE) begin
                if (intr_edge && !consume) begin
                    if (pending != PND_MAX) pending <= pending + 1'b1;
                end else if (consume && !intr_edge) begin
                    pending <= pending - 1'b1;
                end
            end
        end
    end

    // Output stage: address issue -> RAM register -> output register
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            vld_pipe  <= '0;
            row_q1    <= '0;
            o_data    <= '0;
            o_row_idx <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], issue};
            row_q1   <= row;
            if (vld_pipe[1]) begin
                o_data    <= ram_q;
                o_row_idx <= row_q1;
            end
            if (start_go) begin
                o_busy <= 1'b1;
                o_done <= 1'b0;
            end else if (clr_go) begin
                o_busy <= 1'b0;
                o_done <= 1'b0;
            end else if (state == S_DONE && vld_pipe == 2'b00 && o_busy) begin
                o_busy <= 1'b0;
                o_done <= 1'b1;
            end
        end
    end

    img_buf_ram #(
        .DW   (DW),
        .DEPTH(NPIX),
        .AW   (ADDR_W)
    ) u_ram (
        .clk  (axi_clk),
        .we   (wr_acc),
        .waddr(wptr),
        .wdata(i_wr_data),
        .re   (issue),
        .raddr(rd_addr),
        .rdata(ram_q)
    );

endmodule

// File: doc/img_row_streamer.md
Name: img_row_streamer

Overview:
Parametrised image source that feeds the cnn layer-1 input port. It buffers one full image (IMG_W x IMG_H pixels, CH channels) written in raster order, then streams it row by row. The first PREFILL_ROWS rows go back to back; each further row waits for an interrupt pulse from the consumer. It supersedes the bench-side row feeding and adds optional row inversion for BMP sources, multi-channel pixels and a reusable image buffer.

Parameters:
IMG_W, 28, pixels per row
IMG_H, 28, rows per image
PIX_W, 8, bits per channel sample
CH, 1, channels per pixel; data word = PIX_W*CH
PREFILL_ROWS, 4, rows streamed before the first interrupt wait (1..IMG_H)

Ports:
axi_clk  in  1  clock
axi_rst_n  in  1  asynchronous active-low reset
i_wr_valid  in  1  load beat valid
i_wr_data  in  PIX_W*CH  load pixel, raster order (file order)
o_wr_ready  out  1  load beat accepted when high with i_wr_valid
o_load_done  out  1  buffer holds IMG_W*IMG_H pixels
i_clear  in  1  pulse: rewind load pointer, drop o_load_done
i_start  in  1  pulse: begin streaming
i_flip  in  1  row inversion mode, sampled with i_start
i_intr  in  1  consumer request for next row (rising edge counts)
o_data_valid  out  1  output beat valid
o_data  out  PIX_W*CH  output pixel
o_row_idx  out  clog2(IMG_H)  output row number (0-based, stream order) of current beat
o_busy  out  1  streaming in progress
o_done  out  1  level, all rows sent

Behaviour:
- Reset: all outputs 0. Load pointer, pending counter and FSM are cleared. Memory content is undefined after reset.
- States: IDLE, ROW, GAP, WAIT, DONE.
- Load (IDLE or DONE only):
  - o_wr_ready = !o_load_done and not streaming.
  - Each accepted beat writes address wptr; wptr increments.
  - When wptr reaches IMG_W*IMG_H-1 and the beat is accepted, o_load_done rises the next cycle.
  - i_clear in IDLE/DONE: wptr=0, o_load_done=0, o_done=0. i_clear is ignored while o_busy.
- Start:
  - i_start is honoured in IDLE/DONE only if o_load_done=1; otherwise ignored.
  - On start: latch i_flip, row=0, pending=0, o_done=0, o_busy=1, go to ROW.
  - The image is retained, so a repeated start re-streams it.
- ROW:
  - Emits IMG_W consecutive beats, one per cycle, no bubbles.
  - Source row = flip ? IMG_H-1-row : row.
  - RAM read is registered: first o_data_valid occurs 2 cycles after the cycle the FSM enters ROW. o_data/o_row_idx are registered with valid.
  - After the last beat: if row+1 == IMG_H, go to DONE. Else insert exactly one cycle with valid low (GAP). Then: if row+1 < PREFILL_ROWS, go to ROW; else go to WAIT.
- WAIT: if pending>0 or an i_intr rising edge is seen this cycle, consume one request and go to ROW; otherwise hold.
- Interrupts:
  - Rising edges of i_intr are detected with a 1-cycle registered copy.
  - Edges in ROW/GAP increment pending (saturating at IMG_H). Edges in IDLE/DONE are discarded.
  - An edge and a consume in the same cycle leave pending unchanged.
- DONE: o_busy=0, o_done=1 (held until next start/clear/reset).
- PREFILL_ROWS >= IMG_H: whole image streams with no WAIT.
- Reset mid-stream: immediate return to IDLE with o_load_done=0. The image must be reloaded.
- Widths: the address counter is clog2(IMG_W*IMG_H). Counters are compared against params, so non-power-of-two sizes are handled.

Decomposition:
- Shared package cnn_pkg: state enum, IMG_W/IMG_H/PIX_W defaults, and clog2-derived ADDR_W/ROW_W constants.
- One sub-module: img_buf_ram, a simple dual-port synchronous RAM with 1-cycle registered read, inferrable as BRAM.
- FSM, counters and the intr edge logic stay in the top module.

Test Plan:
- Load 784 bytes, value = (addr mod 256), flip=0, start, no intr -> 4 rows (0..3) of 28 beats with 1-cycle gaps; first beat value 0; then valid stays low; o_busy=1.
- Same image with flip=1 -> first row carries values 756..783 mod 256 (last loaded row first); o_row_idx=0.
- After prefill, pulse i_intr 24 times, each after a row completes -> exactly 24 more rows; o_done=1 after row 27; total 784 beats.
- Three intr pulses during row 3 -> rows 4, 5, 6 follow, each with one gap cycle and no WAIT stall; a fourth row then waits.
- i_start before load complete (500 beats) -> ignored, valid stays 0. Finish the load, start -> stream proceeds. i_clear during stream is ignored.
- Assert axi_rst_n low mid-row 2 -> all outputs 0 asynchronously. After release, o_load_done=0 and o_wr_ready=1.
